ycr1_wbb_sram_ctrl: RTL and testbench
=====================================

# ycr1_wbb_sram_ctrl

Burst-capable Wishbone responder that terminates the slave side of the async Wishbone burst bridge and drives a single-port, 1-cycle-latency synchronous SRAM macro (OpenRAM style: active-low chip/write select, byte mask). It accepts single and burst transfers with a word burst count and a burst-ready qualifier, and returns a per-beat ack, a last-beat ack and an error. It sits in the slave clock domain, directly behind the bridge.

## Interface
- AW, 32, Wishbone address width (byte address)
- DW, 32, data width
- BW, 4, byte-select width
- BL, 10, burst count width; 1 = one DW word
- MAW, 9, SRAM word-address width (2^MAW words)

- wbs_clk_i  in  1  single clock, all logic on rising edge
- wbs_rst_n  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  cycle valid
- wbs_stb_i  in  1  strobe; held high for the whole burst
- wbs_adr_i  in  AW  start byte address; held constant during the burst
- wbs_we_i  in  1  1 = write burst
- wbs_dat_i  in  DW  write data; next beat presented after each ack
- wbs_sel_i  in  BW  byte enables, used as SRAM write mask
- wbs_bl_i  in  BL  burst length in words; 0 treated as 1
- wbs_bry_i  in  1  write: beat data valid; read: room for one more read beat
- wbs_dat_o  out  DW  read data
- wbs_ack_o  out  1  per-beat acknowledge
- wbs_lack_o  out  1  last-beat acknowledge (coincides with final ack)
- wbs_err_o  out  1  error, coincides with ack
- sram_csb_o  out  1  SRAM chip select, active-low
- sram_web_o  out  1  SRAM write enable, active-low
- sram_wmask_o  out  BW  SRAM byte write mask
- sram_addr_o  out  MAW  SRAM word address
- sram_din_o  out  DW  SRAM write data
- sram_dout_i  in  DW  SRAM read data, valid 1 cycle after a read select

## Operation
- States: IDLE, WR, RD, GAP.
- IDLE: on cyc&stb, latch word address = wbs_adr_i[MAW+1:2], beat count = bl (0→1), err flag = (wbs_adr_i[AW-1:MAW+2] != 0); go WR if we else RD.
- WR: each cycle with stb&bry_i: drive csb=0, web=0, wmask=sel_i, din=dat_i, addr=current; assert ack combinationally same cycle; increment address, decrement count. Beat with count==1 also asserts lack → GAP.
- RD: issue read (csb=0, web=1) in any cycle with bry_i=1 and issue count>0; increment address, decrement issue count. Registered valid + last flag: ack next cycle with dat_o=sram_dout_i; lack on the beat issued with issue count==1 → GAP after that ack.
- Error burst: no SRAM access (csb stays 1); each beat acked with err=1, dat_o=0, same pacing as a normal burst; lack on last.
- GAP: one cycle, stb ignored (bridge drops stb one cycle after lack) → IDLE.
- Address increments modulo 2^MAW; wrap is silent, no error.
- sel ignored on reads; wmask only meaningful when web=0.

## Timing
- Reset: all Wishbone outputs 0, sram_csb_o=1, sram_web_o=1, wmask/addr/din 0, state IDLE, counters 0.
- Write: stb seen cycle 0 (IDLE), first ack earliest cycle 1; 1 beat/cycle while bry_i=1; ack/lack combinational from bry_i.
- Read: stb cycle 0, first issue cycle 1, first ack cycle 2; 1 beat/cycle while bry_i=1. bry_i low stops issue that cycle; at most one read is in flight, so one ack may follow a cycle where bry_i dropped.
- ack/err/lack are single-cycle pulses per beat; lack never asserted without ack.
- Read data only valid in ack cycles; otherwise dat_o=0.
- bry_i low in WR: no ack, no SRAM write, state held.
- stb dropping mid-burst (protocol violation): return to IDLE after completing any in-flight read beat, no lack.
- Reset mid-burst: immediate IDLE, in-flight read discarded, no ack.

## Structure
- Package ycr1_wbb_pkg: state enum (IDLE, WR, RD, GAP), BL/MAW-derived constants, helper for bl 0→1 normalization.
- No sub-module; SRAM macro instantiated by parent. Beat counter and address incrementer inline.

## Test plan
- Single write adr 0x10, dat 0xA5A5_0001, sel 0xF, bl 1 → ack+lack in cycle 1, SRAM word 4 written; single read back → ack+lack cycle 2 with 0xA5A5_0001.
- Write burst bl 4 from 0x40, bry toggling 1,0,1,1,1 → 4 acks only on bry=1 cycles, lack on 4th, words 16–19 correct.
- Read burst bl 8 from 0x7F8 (MAW 9) → addresses wrap 510,511,0..5; 8 acks, lack on 8th, bry held low 2 cycles mid-burst → exactly one trailing ack then stall.
- Byte write sel 0x2, dat 0x0000_BB00 over 0xFFFF_FFFF → read returns 0xFFFF_BBFF.
- Out-of-range adr 0x0001_0000, read bl 3 → 3 acks all with err=1, dat 0, lack on 3rd, csb never low.
- Assert wbs_rst_n low during read burst beat 2 → outputs to reset values next edge, no further ack; new burst after reset completes normally.

Source files
------------

// File: rtl/ycr1_wbb_pkg.sv
// Shared types and constants for the Wishbone-burst SRAM responder.
package ycr1_wbb_pkg;

  localparam int unsigned BL_W  = 10;
  localparam int unsigned MAW_W = 9;
  localparam int unsigned SRAM_DEPTH = 1 << MAW_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_GAP  = 2'd3
  } wbb_state_e;

  // A zero burst length from the bridge means a single word.
  function automatic logic [BL_W-1:0] norm_bl(input logic [BL_W-1:0] bl);
    return (bl == '0) ? BL_W'(1) : bl;
  endfunction

endpackage

// File: rtl/ycr1_wbb_sram_ctrl.sv
// Burst Wishbone responder driving a 1-cycle-latency single-port SRAM macro.
// state | meaning
// IDLE  | waiting for cyc&stb, latches start address / beat count / range error
// WR    | one write beat per cycle with bry, ack combinational
// RD    | one read issue per cycle with bry, ack one cycle later
// GAP   | single dead cycle after lack while the bridge drops stb
module ycr1_wbb_sram_ctrl
  import ycr1_wbb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = 4,
  parameter int BL  = 10,
  parameter int MAW = 9
) (
  input  logic           wbs_clk_i,
  input  logic           wbs_rst_n,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic [AW-1:0]  wbs_adr_i,
  input  logic           wbs_we_i,
  input  logic [DW-1:0]  wbs_dat_i,
  input  logic [BW-1:0]  wbs_sel_i,
  input  logic [BL-1:0]  wbs_bl_i,
  input  logic           wbs_bry_i,
  output logic [DW-1:0]  wbs_dat_o,
  output logic           wbs_ack_o,
  output logic           wbs_lack_o,
  output logic           wbs_err_o,
  output logic           sram_csb_o,
  output logic           sram_web_o,
  output logic [BW-1:0]  sram_wmask_o,
  output logic [MAW-1:0] sram_addr_o,
  output logic [DW-1:0]  sram_din_o,
  input  logic [DW-1:0]  sram_dout_i
);

  wbb_state_e     state_q, state_d;
  logic [MAW-1:0] addr_q;
  logic [BL-1:0]  cnt_q;
  logic           err_q;
  logic           rd_vld_q;
  logic           rd_last_q;

  logic           req;
  logic           wr_beat;
  logic           rd_issue;
  logic           last_cnt;
  logic [BL-1:0]  cnt_init;
  logic           unused_adr_lsb;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign last_cnt = (cnt_q == BL'(1));
  assign cnt_init = BL'(norm_bl(BL_W'(wbs_bl_i)));
  assign wr_beat  = (state_q == ST_WR) & req & wbs_bry_i;
  assign rd_issue = (state_q == ST_RD) & req & wbs_bry_i & (cnt_q != '0);
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  always_comb begin
    state_d      = state_q;
    wbs_dat_o    = '0;
    wbs_ack_o    = 1'b0;
    wbs_lack_o   = 1'b0;
    wbs_err_o    = 1'b0;
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = addr_q;
    sram_din_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = wbs_we_i ? ST_WR : ST_RD;
      end
      ST_WR: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (wbs_bry_i) begin
          wbs_ack_o  = 1'b1;
          wbs_err_o  = err_q;
          wbs_lack_o = last_cnt;
          // Out-of-range bursts are paced normally but never touch the macro.
          if (!err_q) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = 1'b0;
            sram_wmask_o = wbs_sel_i;
            sram_din_o   = wbs_dat_i;
          end
          if (last_cnt) state_d = ST_GAP;
        end
      end
      ST_RD: begin
        if (rd_vld_q) begin
          wbs_ack_o  = 1'b1;
          wbs_err_o  = err_q;
          wbs_lack_o = rd_last_q;
          wbs_dat_o  = err_q ? '0 : sram_dout_i;
        end
        if (rd_issue && !err_q) sram_csb_o = 1'b0;
        if (rd_vld_q && rd_last_q) state_d = ST_GAP;
        else if (!req)             state_d = ST_IDLE;
      end
      ST_GAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= rd_issue;
      rd_last_q <= rd_issue & last_cnt;
      if ((state_q == ST_IDLE) && req) begin
        addr_q <= wbs_adr_i[MAW+1:2];
        cnt_q  <= cnt_init;
        err_q  <= (wbs_adr_i[AW-1:MAW+2] != '0);
      end else if (wr_beat || rd_issue) begin
        addr_q <= addr_q + MAW'(1);
        cnt_q  <= cnt_q - BL'(1);
      end
    end
  end

endmodule

// File: tb/tb_ycr1_wbb_sram_ctrl.sv
// Randomized bench for ycr1_wbb_sram_ctrl against a word-array reference of the SRAM contents.
module tb_ycr1_wbb_sram_ctrl;
  localparam int AW = 32, DW = 32, BW = 4, BL = 10, MAW = 9;
  localparam int DEPTH = 1 << MAW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cyc = 0, stb = 0, we = 0, bry = 0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] dat_w = '0;
  logic [BW-1:0] sel = '0;
  logic [BL-1:0] bl = '0;
  logic [DW-1:0] dat_r, sdin, sdout;
  logic ack, lack, err, csb, web;
  logic [BW-1:0] wmask;
  logic [MAW-1:0] saddr;

  always #5 clk = ~clk;

  ycr1_wbb_sram_ctrl dut (
    .wbs_clk_i(clk), .wbs_rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_adr_i(adr), .wbs_we_i(we), .wbs_dat_i(dat_w), .wbs_sel_i(sel),
    .wbs_bl_i(bl), .wbs_bry_i(bry), .wbs_dat_o(dat_r), .wbs_ack_o(ack),
    .wbs_lack_o(lack), .wbs_err_o(err), .sram_csb_o(csb), .sram_web_o(web),
    .sram_wmask_o(wmask), .sram_addr_o(saddr), .sram_din_o(sdin),
    .sram_dout_i(sdout)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    for (int b = 0; b < 4; b++) if (m[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  // SRAM macro model: 1-cycle read latency, byte-masked write.
  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) sram_mem[saddr] <= merge(sram_mem[saddr], sdin, wmask);
      else      sdout <= sram_mem[saddr];
    end
  end

  int n_chk = 0, n_pass = 0;
  int bry_pat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic get_bry(output logic b);
    if (bry_pat.size() > 0) b = (bry_pat.pop_front() != 0);
    else b = ($urandom_range(3) != 0);
  endtask

  task automatic end_burst();
    @(negedge clk);
    cyc = 0; stb = 0; bry = 0;
    #1 chk("gap_ack", ack, 0);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [BL-1:0] n,
                          input logic [BW-1:0] s, input logic [DW-1:0] d0, input bit rnd);
    int nb, word, beat, cyc_n;
    bit oor;
    logic b;
    logic [DW-1:0] d;
    nb = (n == 0) ? 1 : int'(n);
    oor = (a[AW-1:MAW+2] != 0);
    word = int'(a[MAW+1:2]);
    beat = 0; cyc_n = 0; d = d0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; bl = n; sel = s; bry = 0; dat_w = d;
    #1 chk("wr_idle_ack", ack, 0);
    while (beat < nb && cyc_n < 200) begin
      @(negedge clk);
      cyc_n++;
      get_bry(b);
      bry = b; dat_w = d;
      #1 chk("wr_ack", ack, b);
      if (ack) begin
        chk("wr_lack", lack, beat == nb - 1);
        chk("wr_err", err, oor);
        chk("wr_csb", csb, oor);
        if (!oor) begin
          chk("wr_web", web, 0);
          chk("wr_addr", saddr, (word + beat) % DEPTH);
          chk("wr_wmask", wmask, s);
          chk("wr_din", sdin, d);
          ref_mem[(word + beat) % DEPTH] = merge(ref_mem[(word + beat) % DEPTH], d, s);
        end
        beat++;
        d = rnd ? $urandom : d + 1;
      end else begin
        chk("wr_stall_csb", csb, 1);
        chk("wr_stall_lack", lack, 0);
      end
    end
    if (beat < nb) chk("wr_timeout", beat, nb);
    end_burst();
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [BL-1:0] n);
    int nb, word, issued, acked, cyc_n, pend_word;
    bit oor, pend, pend_last;
    logic b;
    nb = (n == 0) ? 1 : int'(n);
    oor = (a[AW-1:MAW+2] != 0);
    word = int'(a[MAW+1:2]);
    issued = 0; acked = 0; cyc_n = 0; pend = 0; pend_last = 0; pend_word = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a; bl = n; sel = BW'($urandom); bry = 0;
    #1 chk("rd_idle_ack", ack, 0);
    while (acked < nb && cyc_n < 200) begin
      @(negedge clk);
      cyc_n++;
      get_bry(b);
      bry = b;
      #1 chk("rd_ack", ack, pend);
      if (pend) begin
        chk("rd_lack", lack, pend_last);
        chk("rd_err", err, oor);
        chk("rd_dat", dat_r, oor ? 32'h0 : ref_mem[pend_word]);
        acked++;
      end else begin
        chk("rd_dat_idle", dat_r, 0);
        chk("rd_lack_idle", lack, 0);
      end
      if (b && issued < nb) begin
        chk("rd_csb", csb, oor);
        if (!oor) begin
          chk("rd_web", web, 1);
          chk("rd_addr", saddr, (word + issued) % DEPTH);
        end
        pend = 1;
        pend_word = (word + issued) % DEPTH;
        pend_last = (issued == nb - 1);
        issued++;
      end else begin
        chk("rd_noissue_csb", csb, 1);
        pend = 0;
      end
    end
    if (acked < nb) chk("rd_timeout", acked, nb);
    end_burst();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_lack"}, lack, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_dat"}, dat_r, 0);
    chk({tag, "_csb"}, csb, 1);
    chk({tag, "_web"}, web, 1);
    chk({tag, "_wmask"}, wmask, 0);
    chk({tag, "_addr"}, saddr, 0);
    chk({tag, "_din"}, sdin, 0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1;

    // single write then read back
    bry_pat = '{1};
    wr_burst(32'h10, 1, 4'hF, 32'hA5A5_0001, 0);
    chk("mem_word4", sram_mem[4], 32'hA5A5_0001);
    bry_pat = '{1};
    rd_burst(32'h10, 1);

    // write burst with bry gaps
    bry_pat = '{1, 0, 1, 1, 1};
    wr_burst(32'h40, 4, 4'hF, 32'h1234_0000, 1);
    for (int i = 16; i < 20; i++) chk("mem_burst", sram_mem[i], ref_mem[i]);

    // wrapping read with a 2-cycle bry hole
    bry_pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    rd_burst(32'h7F8, 8);

    // byte-masked write over all-ones
    bry_pat = '{1};
    wr_burst(32'h100, 1, 4'hF, 32'hFFFF_FFFF, 0);
    bry_pat = '{1};
    wr_burst(32'h100, 1, 4'h2, 32'h0000_BB00, 0);
    chk("byte_merge", sram_mem[64], 32'hFFFF_BBFF);
    bry_pat = '{1};
    rd_burst(32'h100, 1);

    // out-of-range read and write, bl 0 treated as 1
    bry_pat = '{1, 1, 1, 1};
    rd_burst(32'h0001_0000, 3);
    wr_burst(32'h0002_0004, 2, 4'hF, 32'hDEAD_0000, 0);
    wr_burst(32'h20, 0, 4'hF, 32'h0BEE_F000, 0);
    rd_burst(32'h20, 0);

    // reset while beat 2 of a read burst is in flight
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h80; bl = 4; bry = 1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rstmid_beat1_ack", ack, 1);
    rst_n = 0;
    #1 chk_reset_outputs("rstmid");
    @(negedge clk);
    #1 chk("rstmid_hold_ack", ack, 0);
    cyc = 0; stb = 0; bry = 0;
    rst_n = 1;
    @(negedge clk);
    #1 chk("rstmid_after_ack", ack, 0);
    rd_burst(32'h80, 4);

    // randomized bursts
    for (int t = 0; t < 40; t++) begin
      ra = AW'({$urandom_range(DEPTH - 1), 2'($urandom)});
      if ($urandom_range(7) == 0) ra[AW-1:MAW+2] = 21'($urandom_range(1, 255));
      if ($urandom_range(1) == 1)
        wr_burst(ra, BL'($urandom_range(6)), BW'($urandom), $urandom, 1);
      else
        rd_burst(ra, BL'($urandom_range(6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
